// File: rtl/riscv_mem_arbiter_pkg.sv
// Shared types and constants for the IF/MEM memory arbiter.
package riscv_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_BUSY_I = 2'd1,
    ARB_BUSY_D = 2'd2
  } arb_state_t;

  // Instruction returned to the fetch port when an access is aborted (addi x0,x0,0).
  localparam logic [31:0] ARB_NOP = 32'h0000_0013;

endpackage

// File: rtl/riscv_arb_timer.sv
// Watchdog counter for an outstanding memory access.
// Clears on the grant edge, counts busy cycles without ack, and flags
// expiry on the TO_CYC-th busy cycle so the arbiter can abort on that edge.
module riscv_arb_timer
  import riscv_mem_arbiter_pkg::*;
#(
  parameter int TO_CYC = 255,
  parameter int TO_W   = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  logic [TO_W-1:0] count;

  // Busy-cycle counter, restarted whenever a new access is granted.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  assign expire = enable && (count == TO_W'(TO_CYC - 1));

endmodule

// File: rtl/riscv_mem_arbiter.sv
// Arbiter sharing one single-port memory between instruction fetch and data ports.
// Data requests win over fetches; each access passes through IDLE, giving one bubble
// between back-to-back accesses. Optional access watchdog: RISCV_ARB_TIMEOUT_EN.
module riscv_mem_arbiter
  import riscv_mem_arbiter_pkg::*;
#(
  parameter int DW     = 32,
  parameter int AW     = 32,
  parameter int TO_CYC = 255,
  parameter int TO_W   = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          if_req_i,
  input  logic [AW-1:0] if_addr_i,
  output logic [DW-1:0] if_data_o,
  output logic          if_valid_o,
  output logic          if_stall_o,
  input  logic          d_rd_en_i,
  input  logic          d_wr_en_i,
  input  logic [AW-1:0] d_addr_i,
  input  logic [DW-1:0] d_wdata_i,
  output logic [DW-1:0] d_rdata_o,
  output logic          d_valid_o,
  output logic          d_stall_o,
  output logic          mem_req_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  input  logic [DW-1:0] mem_rdata_i,
  input  logic          mem_ack_i,
  output logic          err_o
);

  arb_state_t    state, state_next;
  logic          req_next, we_next;
  logic [AW-1:0] addr_next;
  logic [DW-1:0] wdata_next, if_data_next, d_rdata_next;
  logic          if_valid_next, d_valid_next;
  logic          cancel, cancel_next;

  logic d_req, busy, port_req, cancel_now, done, abort, finish, expire;

  assign d_req      = d_rd_en_i | d_wr_en_i;
  assign busy       = (state != ARB_IDLE);
  assign port_req   = (state == ARB_BUSY_I) ? if_req_i : d_req;
  // A flush seen on any busy cycle, including the ack cycle, kills the valid pulse.
  assign cancel_now = cancel | (busy & ~port_req);
  assign done       = busy & mem_ack_i;
  assign abort      = busy & ~mem_ack_i & expire;
  assign finish     = done | abort;

  assign if_stall_o = if_req_i & ~if_valid_o;
  assign d_stall_o  = d_req & ~d_valid_o;

`ifdef RISCV_ARB_TIMEOUT_EN
  logic grant;
  logic timer_en;

  assign grant    = (state == ARB_IDLE) & (d_req | if_req_i);
  assign timer_en = busy & ~mem_ack_i;

  riscv_arb_timer #(
    .TO_CYC (TO_CYC),
    .TO_W   (TO_W)
  ) u_timer (
    .clk    (clk_i),
    .rst    (rst_i),
    .clear  (grant),
    .enable (timer_en),
    .expire (expire)
  );

  // Sticky error flag: only a reset clears a recorded timeout.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_o <= 1'b0;
    end else if (abort) begin
      err_o <= 1'b1;
    end
  end
`else
  assign expire = 1'b0;
  assign err_o  = 1'b0;
`endif

  // State, memory-side and response registers; reset abandons any access in flight.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= ARB_IDLE;
      cancel      <= 1'b0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      if_data_o   <= '0;
      d_rdata_o   <= '0;
      if_valid_o  <= 1'b0;
      d_valid_o   <= 1'b0;
    end else begin
      state       <= state_next;
      cancel      <= cancel_next;
      mem_req_o   <= req_next;
      mem_we_o    <= we_next;
      mem_addr_o  <= addr_next;
      mem_wdata_o <= wdata_next;
      if_data_o   <= if_data_next;
      d_rdata_o   <= d_rdata_next;
      if_valid_o  <= if_valid_next;
      d_valid_o   <= d_valid_next;
    end
  end

  // Grant selection in IDLE, completion/abort handling while busy.
  always_comb begin
    state_next    = state;
    cancel_next   = cancel;
    req_next      = mem_req_o;
    we_next       = mem_we_o;
    addr_next     = mem_addr_o;
    wdata_next    = mem_wdata_o;
    if_data_next  = if_data_o;
    d_rdata_next  = d_rdata_o;
    if_valid_next = 1'b0;
    d_valid_next  = 1'b0;

    case (state)
      ARB_IDLE: begin
        cancel_next = 1'b0;
        if (d_req) begin
          state_next = ARB_BUSY_D;
          req_next   = 1'b1;
          we_next    = d_wr_en_i;
          addr_next  = d_addr_i;
          wdata_next = d_wdata_i;
        end else if (if_req_i) begin
          state_next = ARB_BUSY_I;
          req_next   = 1'b1;
          we_next    = 1'b0;
          addr_next  = if_addr_i;
          wdata_next = '0;
        end
      end
      ARB_BUSY_I: begin
        cancel_next = cancel_now;
        if (finish) begin
          state_next    = ARB_IDLE;
          req_next      = 1'b0;
          if_data_next  = done ? mem_rdata_i : DW'(ARB_NOP);
          if_valid_next = ~cancel_now;
        end
      end
      ARB_BUSY_D: begin
        cancel_next = cancel_now;
        if (finish) begin
          state_next   = ARB_IDLE;
          req_next     = 1'b0;
          if (!mem_we_o) begin
            d_rdata_next = done ? mem_rdata_i : '0;
          end
          d_valid_next = ~cancel_now;
        end
      end
      default: begin
        state_next = ARB_IDLE;
        req_next   = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Self-checking bench for riscv_mem_arbiter: directed scenarios plus randomized
// fetch/load/store mixes checked against a cycle-count and memory-image model.
module tb_riscv_mem_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        if_req_i = 1'b0;
  logic [31:0] if_addr_i = '0;
  logic [31:0] if_data_o;
  logic        if_valid_o, if_stall_o;
  logic        d_rd_en_i = 1'b0;
  logic        d_wr_en_i = 1'b0;
  logic [31:0] d_addr_i = '0;
  logic [31:0] d_wdata_i = '0;
  logic [31:0] d_rdata_o;
  logic        d_valid_o, d_stall_o;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [31:0] mem_rdata_i = '0;
  logic        mem_ack_i = 1'b0;
  logic        err_o;

  int tests_run = 0;
  int tests_failed = 0;

  // Expected contents of memory and of the two response registers.
  logic [31:0] ref_mem [bit [31:0]];
  logic [31:0] exp_if_data = '0;
  logic [31:0] exp_d_rdata = '0;
  logic        exp_err = 1'b0;

  // Memory responder state: its own image, per-access ack delays, forced ack.
  logic [31:0] sim_mem [bit [31:0]];
  int          delay_q [$];
  bit          late_ack = 1'b0;
  bit          resp_active = 1'b0;
  bit          resp_done = 1'b0;
  int          resp_rem = 0;

  riscv_mem_arbiter #(
    .DW(32), .AW(32), .TO_CYC(8), .TO_W(8)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .if_req_i    (if_req_i),
    .if_addr_i   (if_addr_i),
    .if_data_o   (if_data_o),
    .if_valid_o  (if_valid_o),
    .if_stall_o  (if_stall_o),
    .d_rd_en_i   (d_rd_en_i),
    .d_wr_en_i   (d_wr_en_i),
    .d_addr_i    (d_addr_i),
    .d_wdata_i   (d_wdata_i),
    .d_rdata_o   (d_rdata_o),
    .d_valid_o   (d_valid_o),
    .d_stall_o   (d_stall_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_rdata_i (mem_rdata_i),
    .mem_ack_i   (mem_ack_i),
    .err_o       (err_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  function automatic logic [31:0] sim_read(input logic [31:0] a);
    return sim_mem.exists(a) ? sim_mem[a] : init_word(a);
  endfunction

  // Memory model: acks each request after the delay queued for it, junk data otherwise.
  always @(posedge clk_i) begin
    #2;
    mem_ack_i   = 1'b0;
    mem_rdata_i = $urandom;
    if (late_ack) begin
      mem_ack_i = 1'b1;
    end else if (mem_req_o && !resp_done) begin
      if (!resp_active) begin
        resp_active = 1'b1;
        resp_rem    = (delay_q.size() > 0) ? delay_q.pop_front() : 1;
      end
      if (resp_rem <= 0) begin
        mem_ack_i = 1'b1;
        resp_done = 1'b1;
        if (mem_we_o) sim_mem[mem_addr_o] = mem_wdata_o;
        else          mem_rdata_i = sim_read(mem_addr_o);
      end else begin
        resp_rem--;
      end
    end
    if (!mem_req_o) begin
      resp_active = 1'b0;
      resp_done   = 1'b0;
    end
  end

  task automatic applyStimulus(input logic f, input logic [31:0] fa, input logic rd,
                               input logic wr, input logic [31:0] da, input logic [31:0] wd);
    if_req_i  = f;
    if_addr_i = fa;
    d_rd_en_i = rd;
    d_wr_en_i = wr;
    d_addr_i  = da;
    d_wdata_i = wd;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // One arbitration episode: optional data access and/or fetch issued together at cycle 0.
  // Each access occupies (delay + 2) cycles from the cycle it is seen in IDLE.
  task automatic run_access(input bit do_if, input logic [31:0] fa, input int fd, input int f_cancel,
                            input bit do_d, input bit dwe, input logic [31:0] da,
                            input logic [31:0] dwd, input int dd);
    int d_vc, f_vc, f_lo, f_hi, f_base, last;
    d_vc = -1; f_vc = -1; f_lo = -1; f_hi = -2; f_base = 0; last = 0;
    if (do_d) begin
      delay_q.push_back(dd);
      d_vc   = dd + 2;
      last   = d_vc;
      f_base = d_vc;
      if (dwe) ref_mem[da] = dwd;
      else     exp_d_rdata = ref_read(da);
    end
    if (do_if) begin
      delay_q.push_back(fd);
      f_lo        = f_base + 1;
      f_hi        = f_base + 1 + fd;
      exp_if_data = ref_read(fa);
      f_vc        = (f_cancel >= 0) ? -1 : f_hi + 1;
      last        = f_hi + 1;
    end
    for (int c = 0; c <= last; c++) begin
      bit f_on, d_on, in_d, in_f;
      f_on = do_if && (c < ((f_cancel >= 0) ? f_cancel : f_vc));
      d_on = do_d && (c < d_vc);
      applyStimulus(f_on, fa, d_on & ~dwe, d_on & dwe, da, dwd);
      #1;
      in_d = do_d && (c >= 1) && (c <= dd + 1);
      in_f = do_if && (c >= f_lo) && (c <= f_hi);
      checkOutput("mem_req", 32'(mem_req_o), 32'(in_d | in_f));
      if (in_d) begin
        checkOutput("mem_addr_d", mem_addr_o, da);
        checkOutput("mem_we_d", 32'(mem_we_o), 32'(dwe));
        if (dwe) checkOutput("mem_wdata", mem_wdata_o, dwd);
      end
      if (in_f) begin
        checkOutput("mem_addr_if", mem_addr_o, fa);
        checkOutput("mem_we_if", 32'(mem_we_o), 32'd0);
      end
      checkOutput("if_valid", 32'(if_valid_o), 32'(c == f_vc));
      checkOutput("d_valid", 32'(d_valid_o), 32'(c == d_vc));
      checkOutput("if_stall", 32'(if_stall_o), 32'(f_on));
      checkOutput("d_stall", 32'(d_stall_o), 32'(d_on));
      checkOutput("err", 32'(err_o), 32'(exp_err));
      if (c == d_vc) checkOutput("d_rdata", d_rdata_o, exp_d_rdata);
      if (do_if && c == last) checkOutput("if_data", if_data_o, exp_if_data);
      @(posedge clk_i); #1;
    end
  endtask

  initial begin
    int kind, fd, dd, fc;
    logic [31:0] fa, da, wd;

    // Reset: every registered output must come up zero.
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
    repeat (3) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    checkOutput("rst_mem_req", 32'(mem_req_o), 32'd0);
    checkOutput("rst_mem_we", 32'(mem_we_o), 32'd0);
    checkOutput("rst_mem_addr", mem_addr_o, 32'd0);
    checkOutput("rst_mem_wdata", mem_wdata_o, 32'd0);
    checkOutput("rst_if_data", if_data_o, 32'd0);
    checkOutput("rst_d_rdata", d_rdata_o, 32'd0);
    checkOutput("rst_if_valid", 32'(if_valid_o), 32'd0);
    checkOutput("rst_d_valid", 32'(d_valid_o), 32'd0);
    checkOutput("rst_err", 32'(err_o), 32'd0);
    @(posedge clk_i); #1;

    // Fetch only with minimum latency.
    ref_mem[32'h100] = 32'h0050_0093;
    sim_mem[32'h100] = 32'h0050_0093;
    run_access(1'b1, 32'h100, 1, -1, 1'b0, 1'b0, '0, '0, 1);

    // Load and fetch together: data first, then fetch after a bubble.
    run_access(1'b1, 32'h104, 1, -1, 1'b1, 1'b0, 32'h200, '0, 1);

    // Store with slow memory: d_rdata_o keeps the previous load value.
    run_access(1'b0, '0, 1, -1, 1'b1, 1'b1, 32'h300, 32'hDEAD_BEEF, 4);

    // Cancelled fetch, then a normal fetch.
    run_access(1'b1, 32'h400, 3, 2, 1'b0, 1'b0, '0, '0, 1);
    run_access(1'b1, 32'h404, 1, -1, 1'b0, 1'b0, '0, '0, 1);

    // Stray ack while idle must not disturb anything.
    late_ack = 1'b1;
    @(posedge clk_i); #1;
    late_ack = 1'b0;
    checkOutput("idle_ack_req", 32'(mem_req_o), 32'd0);
    checkOutput("idle_ack_if_valid", 32'(if_valid_o), 32'd0);
    checkOutput("idle_ack_d_valid", 32'(d_valid_o), 32'd0);
    checkOutput("idle_ack_if_data", if_data_o, exp_if_data);
    checkOutput("idle_ack_d_rdata", d_rdata_o, exp_d_rdata);
    @(posedge clk_i); #1;

    // Reset one cycle before the ack of a load.
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 32'h500, '0);
    delay_q.push_back(10);
    @(posedge clk_i); #1;
    checkOutput("mid_rst_req", 32'(mem_req_o), 32'd1);
    checkOutput("mid_rst_addr", mem_addr_o, 32'h500);
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i    = 1'b0;
    late_ack = 1'b1;
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
    exp_if_data = '0;
    exp_d_rdata = '0;
    checkOutput("post_rst_req", 32'(mem_req_o), 32'd0);
    checkOutput("post_rst_we", 32'(mem_we_o), 32'd0);
    checkOutput("post_rst_addr", mem_addr_o, 32'd0);
    checkOutput("post_rst_wdata", mem_wdata_o, 32'd0);
    checkOutput("post_rst_if_data", if_data_o, 32'd0);
    checkOutput("post_rst_d_rdata", d_rdata_o, 32'd0);
    checkOutput("post_rst_d_valid", 32'(d_valid_o), 32'd0);
    @(posedge clk_i); #1;
    late_ack = 1'b0;
    checkOutput("late_ack_req", 32'(mem_req_o), 32'd0);
    checkOutput("late_ack_d_valid", 32'(d_valid_o), 32'd0);
    checkOutput("late_ack_if_valid", 32'(if_valid_o), 32'd0);
    checkOutput("late_ack_d_rdata", d_rdata_o, 32'd0);
    @(posedge clk_i); #1;

    // Randomized mix of fetches, loads, stores and collisions.
    for (int i = 0; i < 40; i++) begin
      kind = int'($urandom_range(0, 4));
      fd   = int'($urandom_range(1, 4));
      dd   = int'($urandom_range(1, 4));
      fa   = 32'h1000 + (32'($urandom_range(0, 15)) << 2);
      da   = 32'h1000 + (32'($urandom_range(0, 15)) << 2);
      wd   = $urandom;
      fc   = -1;
      if (kind == 0 && $urandom_range(0, 3) == 0) fc = int'($urandom_range(1 + fd, 1));
      case (kind)
        0: run_access(1'b1, fa, fd, fc, 1'b0, 1'b0, '0, '0, 1);
        1: run_access(1'b0, '0, 1, -1, 1'b1, 1'b0, da, '0, dd);
        2: run_access(1'b0, '0, 1, -1, 1'b1, 1'b1, da, wd, dd);
        3: run_access(1'b1, fa, fd, -1, 1'b1, 1'b0, da, '0, dd);
        default: run_access(1'b1, fa, fd, -1, 1'b1, 1'b1, da, wd, dd);
      endcase
    end

`ifdef RISCV_ARB_TIMEOUT_EN
    // Unanswered fetch: abort after 8 busy cycles with a NOP and a sticky error.
    delay_q.push_back(1000);
    for (int c = 0; c <= 11; c++) begin
      applyStimulus(c < 9, 32'h600, 1'b0, 1'b0, '0, '0);
      #1;
      checkOutput("to_mem_req", 32'(mem_req_o), 32'(c >= 1 && c <= 8));
      checkOutput("to_if_valid", 32'(if_valid_o), 32'(c == 9));
      checkOutput("to_err", 32'(err_o), 32'(c >= 9));
      if (c == 9) checkOutput("to_if_data", if_data_o, 32'h0000_0013);
      @(posedge clk_i); #1;
    end
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    checkOutput("to_err_cleared", 32'(err_o), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
